// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared pointer math and read-side state encoding for the fifo block
package fifo_pkg;

   // Default geometry; instances override ADDR_WIDTH and size their own pointers
   localparam int ADDR_WIDTH_DEF = 13;
   localparam int PTR_W          = ADDR_WIDTH_DEF + 1;

   // Pointer helpers take zero-extended pointers so one definition serves any width
   localparam int CALC_W = 32;

   localparam logic ST_EMPTY = 1'b0;
   localparam logic ST_FULL  = 1'b1;

   typedef enum logic {
      S_EMPTY = ST_EMPTY,
      S_FULL  = ST_FULL
   } rd_state_t;

   // Same pointer value (including wrap bit) means nothing stored
   function automatic logic ptr_empty(input logic [CALC_W-1:0] w, input logic [CALC_W-1:0] r);
      return w == r;
   endfunction

   // Full when the pointers differ only in the wrap bit at position aw
   function automatic logic ptr_full(input logic [CALC_W-1:0] w, input logic [CALC_W-1:0] r,
                                     input int aw);
      return (w ^ r) == (CALC_W'(1) << aw);
   endfunction

   // Stored word count, modulo the pointer range of aw+1 bits
   function automatic logic [CALC_W-1:0] ptr_level(input logic [CALC_W-1:0] w,
                                                   input logic [CALC_W-1:0] r, input int aw);
      logic [CALC_W-1:0] mask;
      mask = (CALC_W'(1) << (aw + 1)) - CALC_W'(1);
      return (w - r) & mask;
   endfunction

endpackage

// File: rtl/fifo_ptr.sv
// rtl/fifo_ptr.sv - wrapping pointer counter with increment enable and synchronous load
module fifo_ptr #(
   parameter int W = 14
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] ptr
);

   // Load wins over increment; the counter wraps naturally over W bits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (load) begin
         ptr <= load_val;
      end else if (inc) begin
         ptr <= ptr + W'(1);
      end
   end

endmodule

// File: rtl/fifo_read_ctrl.sv
// rtl/fifo_read_ctrl.sv - fifo read side: RAM read pointer and registered valid/ready output
module fifo_read_ctrl
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 13
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic [ADDR_WIDTH:0]   wr_ptr,
   output logic [ADDR_WIDTH:0]   rd_ptr,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic                  ram_oe,
   input  logic [DATA_WIDTH-1:0] ram_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  ram_empty,
   output logic [ADDR_WIDTH:0]   level
);

   localparam int PW = ADDR_WIDTH + 1;

   rd_state_t state;
   logic      fetch;
   logic      pop;

   assign ram_empty = ptr_empty(CALC_W'(wr_ptr), CALC_W'(rd_ptr));
   assign level     = PW'(ptr_level(CALC_W'(wr_ptr), CALC_W'(rd_ptr), ADDR_WIDTH));
   assign ram_addr  = rd_ptr[ADDR_WIDTH-1:0];

   // Output register can take a word when it is empty or being drained this cycle
   assign fetch  = (state == S_EMPTY) | m_ready;
   assign pop    = fetch & ~ram_empty & ~flush;
   assign ram_oe = pop;

   // Read pointer: flush jumps to the writer's pointer, a pop advances by one
   fifo_ptr #(
      .W(PW)
   ) u_rd_ptr (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc      (pop),
      .load     (flush),
      .load_val (wr_ptr),
      .ptr      (rd_ptr)
   );

   // Output register FSM: EMPTY holds nothing, FULL holds a word awaiting acceptance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_EMPTY;
         m_valid <= 1'b0;
         m_data  <= '0;
      end else if (flush) begin
         state   <= S_EMPTY;
         m_valid <= 1'b0;
      end else if (pop) begin
         state   <= S_FULL;
         m_valid <= 1'b1;
         m_data  <= ram_data;
      end else if (fetch) begin
         state   <= S_EMPTY;
         m_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// tb/tb_fifo_read_ctrl.sv - randomized scenario bench for fifo_read_ctrl with RAM and writer models
`timescale 1ns/1ps
module tb_fifo_read_ctrl;

   localparam int DW    = 8;
   localparam int AW    = 2;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          flush;
   logic          m_ready;
   logic          wr_en;
   logic [DW-1:0] wr_data;
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic [AW-1:0] ram_addr;
   logic          ram_oe;
   logic [DW-1:0] ram_data;
   logic          m_valid;
   logic [DW-1:0] m_data;
   logic          ram_empty;
   logic [AW:0]   level;

   logic [DW-1:0] mem [DEPTH];

   always #5 clk = ~clk;

   fifo_read_ctrl #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .wr_ptr    (wr_ptr),
      .rd_ptr    (rd_ptr),
      .ram_addr  (ram_addr),
      .ram_oe    (ram_oe),
      .ram_data  (ram_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .ram_empty (ram_empty),
      .level     (level)
   );

   // Dual-port RAM: combinational read port, clocked write port driven by the writer
   assign ram_data = mem[ram_addr];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
      end else if (wr_en) begin
         mem[wr_ptr[AW-1:0]] <= wr_data;
         wr_ptr <= wr_ptr + 3'd1;
      end
   end

   // Reference model: words still in RAM, the output register, and pointer counts
   logic [DW-1:0] ram_q [$];
   logic          mv;
   logic [DW-1:0] md;
   int            m_rd;
   int            m_wr;

   // Per-step observations handed back to the scenario tasks
   logic          obs_oe;
   logic          exp_oe;
   logic          xfer;
   logic [DW-1:0] xfer_data;
   logic          wrote;

   int n_checks;
   int n_errors;

   task automatic model_reset();
      ram_q.delete();
      mv   = 1'b0;
      md   = '0;
      m_rd = 0;
      m_wr = 0;
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      wr_en   = 1'b0;
      flush   = 1'b0;
      m_ready = 1'b0;
      wr_data = '0;
      #1;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // One clock: drive at the falling edge, sample, advance the model, wait for the next fall
   task automatic step(input bit we, input logic [DW-1:0] d, input bit rdy, input bit fl);
      bit fetch_m;
      bit pop_m;
      wr_en   = we && !fl && (ram_q.size() < DEPTH);
      wr_data = d;
      m_ready = rdy;
      flush   = fl;
      #1;
      wrote     = wr_en;
      obs_oe    = ram_oe;
      xfer      = m_valid && m_ready;
      xfer_data = m_data;
      fetch_m   = !mv || rdy;
      pop_m     = fetch_m && (ram_q.size() > 0) && !fl;
      exp_oe    = pop_m;
      if (fl) begin
         ram_q.delete();
         mv   = 1'b0;
         m_rd = m_wr;
      end else if (pop_m) begin
         md = ram_q.pop_front();
         mv = 1'b1;
         m_rd++;
      end else if (fetch_m) begin
         mv = 1'b0;
      end
      if (wr_en) begin
         ram_q.push_back(d);
         m_wr++;
      end
      @(posedge clk);
      @(negedge clk);
      wr_en = 1'b0;
      flush = 1'b0;
   endtask

   task automatic test_reset();
      n_checks++; if (rd_ptr !== 3'd0) begin n_errors++; $display("FAIL reset_rd_ptr got %0d want 0", rd_ptr); end
      n_checks++; if (m_valid !== 1'b0) begin n_errors++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
      n_checks++; if (m_data !== 8'h00) begin n_errors++; $display("FAIL reset_m_data got %h want 00", m_data); end
      n_checks++; if (ram_empty !== 1'b1) begin n_errors++; $display("FAIL reset_ram_empty got %b want 1", ram_empty); end
      step(1'b1, 8'h11, 1'b0, 1'b0);
      step(1'b1, 8'h22, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      n_checks++; if (m_valid !== 1'b1 || m_data !== 8'h11) begin n_errors++; $display("FAIL pre_reset_word got %b/%h want 1/11", m_valid, m_data); end
      // Asynchronous reset mid-stream, checked before any clock edge
      rst_n = 1'b0;
      #1;
      n_checks++; if (rd_ptr !== 3'd0) begin n_errors++; $display("FAIL midrun_rd_ptr got %0d want 0", rd_ptr); end
      n_checks++; if (m_valid !== 1'b0) begin n_errors++; $display("FAIL midrun_m_valid got %b want 0", m_valid); end
      n_checks++; if (m_data !== 8'h00) begin n_errors++; $display("FAIL midrun_m_data got %h want 00", m_data); end
      n_checks++; if (ram_empty !== 1'b1) begin n_errors++; $display("FAIL midrun_ram_empty got %b want 1", ram_empty); end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single();
      do_reset();
      step(1'b1, 8'hA5, 1'b0, 1'b0);
      n_checks++; if (m_valid !== 1'b0) begin n_errors++; $display("FAIL single_early_valid got %b want 0", m_valid); end
      step(1'b0, 8'h00, 1'b0, 1'b0);
      n_checks++; if (m_valid !== 1'b1 || m_data !== 8'hA5) begin n_errors++; $display("FAIL single_latency got %b/%h want 1/a5", m_valid, m_data); end
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 8'h00, 1'b0, 1'b0);
         n_checks++; if (m_valid !== 1'b1 || m_data !== 8'hA5) begin n_errors++; $display("FAIL single_hold%0d got %b/%h want 1/a5", i, m_valid, m_data); end
      end
      step(1'b0, 8'h00, 1'b1, 1'b0);
      n_checks++; if (!xfer || xfer_data !== 8'hA5) begin n_errors++; $display("FAIL single_xfer got %b/%h want 1/a5", xfer, xfer_data); end
      n_checks++; if (m_valid !== 1'b0 || rd_ptr !== 3'd1) begin n_errors++; $display("FAIL single_drain got %b/%0d want 0/1", m_valid, rd_ptr); end
   endtask

   task automatic test_stream();
      logic [DW-1:0] got [$];
      int            idx [$];
      do_reset();
      for (int k = 0; k < 9; k++) begin
         if (k < 5) step(1'b1, 8'(k + 1), 1'b1, 1'b0);
         else       step(1'b0, 8'h00, 1'b1, 1'b0);
         if (xfer) begin
            got.push_back(xfer_data);
            idx.push_back(k);
         end
      end
      n_checks++; if (got.size() !== 5) begin n_errors++; $display("FAIL stream_count got %0d want 5", got.size()); end
      for (int i = 0; i < got.size() && i < 5; i++) begin
         n_checks++; if (got[i] !== 8'(i + 1)) begin n_errors++; $display("FAIL stream_word%0d got %h want %h", i, got[i], 8'(i + 1)); end
         n_checks++; if (idx[i] !== idx[0] + i) begin n_errors++; $display("FAIL stream_gap%0d got cycle %0d want %0d", i, idx[i], idx[0] + i); end
      end
      n_checks++; if (rd_ptr !== 3'd5 || level !== 3'd0) begin n_errors++; $display("FAIL stream_end got rd_ptr %0d level %0d want 5/0", rd_ptr, level); end
   endtask

   task automatic test_wrap();
      logic [DW-1:0] sent [$];
      logic [DW-1:0] d;
      int            n_sent;
      int            n_got;
      int            budget;
      bit            seen4;
      bit            seen8;
      do_reset();
      n_sent = 0;
      n_got  = 0;
      seen4  = 1'b0;
      seen8  = 1'b0;
      budget = 0;
      while (ram_q.size() < DEPTH && budget < 20) begin
         d = 8'($urandom);
         step(1'b1, d, 1'b0, 1'b0);
         if (wrote) begin sent.push_back(d); n_sent++; end
         budget++;
      end
      n_checks++; if (level !== 3'd4 || ram_empty !== 1'b0) begin n_errors++; $display("FAIL wrap_full got level %0d empty %b want 4/0", level, ram_empty); end
      budget = 0;
      while (n_got < 14 && budget < 200) begin
         d = 8'($urandom);
         step(n_sent < 14, d, budget[0], 1'b0);
         if (wrote) begin sent.push_back(d); n_sent++; end
         if (xfer) begin
            n_got++;
            n_checks++;
            if (sent.size() == 0 || xfer_data !== sent[0]) begin
               n_errors++; $display("FAIL wrap_order%0d got %h want %h", n_got, xfer_data, (sent.size() > 0) ? sent[0] : 8'hxx);
            end
            if (sent.size() > 0) void'(sent.pop_front());
         end
         n_checks++; if (level !== 3'(ram_q.size())) begin n_errors++; $display("FAIL wrap_level got %0d want %0d", level, ram_q.size()); end
         if (m_rd == 4 && !seen4) begin
            seen4 = 1'b1;
            n_checks++; if (rd_ptr !== 3'b100) begin n_errors++; $display("FAIL wrap_msb4 got %b want 100", rd_ptr); end
         end
         if (m_rd == 8 && !seen8) begin
            seen8 = 1'b1;
            n_checks++; if (rd_ptr !== 3'b000) begin n_errors++; $display("FAIL wrap_msb8 got %b want 000", rd_ptr); end
         end
         budget++;
      end
      n_checks++; if (n_got !== 14 || !seen4 || !seen8) begin n_errors++; $display("FAIL wrap_timeout got %0d words want 14", n_got); end
   endtask

   task automatic test_backpressure();
      do_reset();
      step(1'b1, 8'h5A, 1'b0, 1'b0);
      step(1'b1, 8'h6B, 1'b0, 1'b0);
      n_checks++; if (m_valid !== 1'b1 || m_data !== 8'h5A) begin n_errors++; $display("FAIL bp_start got %b/%h want 1/5a", m_valid, m_data); end
      for (int i = 0; i < 3; i++) begin
         step(i < 2, 8'(8'h70 + i), 1'b0, 1'b0);
         n_checks++; if (obs_oe !== 1'b0) begin n_errors++; $display("FAIL bp_oe%0d got %b want 0", i, obs_oe); end
         n_checks++; if (m_data !== 8'h5A || rd_ptr !== 3'd1) begin n_errors++; $display("FAIL bp_hold%0d got %h/%0d want 5a/1", i, m_data, rd_ptr); end
      end
      n_checks++; if (level !== 3'd3) begin n_errors++; $display("FAIL bp_level got %0d want 3", level); end
   endtask

   task automatic test_flush();
      do_reset();
      for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      n_checks++; if (level !== 3'd3 || m_valid !== 1'b1) begin n_errors++; $display("FAIL flush_setup got level %0d valid %b want 3/1", level, m_valid); end
      step(1'b0, 8'h00, 1'b0, 1'b1);
      n_checks++; if (obs_oe !== 1'b0) begin n_errors++; $display("FAIL flush_oe got %b want 0", obs_oe); end
      n_checks++; if (m_valid !== 1'b0 || level !== 3'd0) begin n_errors++; $display("FAIL flush_result got valid %b level %0d want 0/0", m_valid, level); end
      n_checks++; if (rd_ptr !== 3'(m_wr) || rd_ptr !== wr_ptr) begin n_errors++; $display("FAIL flush_ptr got %0d want %0d", rd_ptr, 3'(m_wr)); end
      step(1'b1, 8'h3C, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      n_checks++; if (m_valid !== 1'b1 || m_data !== 8'h3C) begin n_errors++; $display("FAIL flush_next got %b/%h want 1/3c", m_valid, m_data); end
   endtask

   task automatic test_random();
      do_reset();
      for (int k = 0; k < 300; k++) begin
         step($urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 99) < 3);
         n_checks++; if (obs_oe !== exp_oe) begin n_errors++; $display("FAIL rand_oe step %0d got %b want %b", k, obs_oe, exp_oe); end
         n_checks++; if (m_valid !== mv) begin n_errors++; $display("FAIL rand_valid step %0d got %b want %b", k, m_valid, mv); end
         if (mv) begin
            n_checks++; if (m_data !== md) begin n_errors++; $display("FAIL rand_data step %0d got %h want %h", k, m_data, md); end
         end
         n_checks++; if (rd_ptr !== 3'(m_rd)) begin n_errors++; $display("FAIL rand_rd_ptr step %0d got %0d want %0d", k, rd_ptr, 3'(m_rd)); end
         n_checks++; if (level !== 3'(ram_q.size())) begin n_errors++; $display("FAIL rand_level step %0d got %0d want %0d", k, level, ram_q.size()); end
         n_checks++; if (ram_empty !== (ram_q.size() == 0)) begin n_errors++; $display("FAIL rand_empty step %0d got %b want %b", k, ram_empty, ram_q.size() == 0); end
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      do_reset();
      test_reset();
      test_single();
      test_stream();
      test_wrap();
      test_backpressure();
      test_flush();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
